// File: rtl/md_sched.sv
// md_sched: issue scheduler for the multiply/divide unit in the E stage.
// Tracks the MD unit's busy window with an internal down-counter, stalls
// any MD instruction (including HI/LO moves) until the unit is free, and
// emits the start / HI-LO write pulses.
// Optional build macro MD_SCHED_PERF_EN adds stall-cycle and issue counters;
// without it both counter outputs read 0 and no counter registers exist.
module md_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic        flush,
  input  logic        md_busy,
  output logic        start,
  output logic        md_mul,
  output logic        md_signed,
  output logic        md_ovrd,
  output logic        md_ovrd_hi,
  output logic        rd_hi,
  output logic        stall,
  output logic [3:0]  busy_cnt,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_issued
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;

  logic md_req;
  logic busy_int;
  logic is_arith;
  logic is_move;

  // Busy-window length for the operation being launched.
  function automatic logic [3:0] op_latency(input logic is_mul);
    return is_mul ? MUL_CNT : DIV_CNT;
  endfunction

  // Instruction classification and the stall / issue decisions.
  always_comb begin
    is_arith   = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
    is_move    = (e_md_op == OP_MTHI) || (e_md_op == OP_MTLO);
    md_req     = e_valid && (e_md_op >= OP_MULT) && (e_md_op <= OP_MTLO);
    busy_int   = (busy_cnt != 4'd0);
    stall      = !rst && md_req && (busy_int || md_busy);
    start      = !rst && e_valid && is_arith && !stall && !flush;
    md_ovrd    = !rst && e_valid && is_move && !stall && !flush;
    md_mul     = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
    md_signed  = (e_md_op == OP_MULT) || (e_md_op == OP_DIV);
    md_ovrd_hi = (e_md_op == OP_MTHI);
    rd_hi      = (e_md_op == OP_MFHI);
  end

  // Busy-window FSM: load the latency on start, count down to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy_cnt <= op_latency(md_mul);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (busy_cnt <= 4'd1) begin
            busy_cnt <= 4'd0;
            state    <= IDLE;
          end else begin
            busy_cnt <= busy_cnt - 4'd1;
          end
        end
        default: begin
          busy_cnt <= 4'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef MD_SCHED_PERF_EN
  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      md_issued    <= 32'd0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (start) md_issued    <= md_issued + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign md_issued    = 32'd0;
`endif

endmodule
